branch_resolve_unit: RTL and testbench

// Parametrised, pipelined branch-condition resolver for the datapath.
// - Evaluates the branch condition field of a branch IR against the Ra operand.
// - Computes the target PC.
// - Predicts via a per-PC table of 2-bit saturating counters and flags mispredicts.
// - Holds the CON flag and taken/mispredict statistics.

---
 rtl/branch_resolve_unit.sv | 154 +++++++++++++++
 tb/tb_branch_resolve_unit.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_unit.sv
// Two-stage branch resolver: condition test, target add, 2-bit counter prediction, CON flag and stats.
// Latency: request accepted in cycle t gives its response in cycle t+2, one per cycle.
// Backpressure: a stalled response holds S2, S1 fills behind it, and req_ready then drops.
module branch_resolve_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int PC_WIDTH   = 32,
    parameter int EXT_MODES  = 1,
    parameter int BHT_DEPTH  = 16,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [31:0]           ir,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic [PC_WIDTH-1:0]   pc,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic                  resp_taken,
    output logic                  resp_pred,
    output logic                  resp_mispred,
    output logic [PC_WIDTH-1:0]   resp_target,
    output logic                  con_out,
    output logic [CNT_WIDTH-1:0]  taken_count,
    output logic [CNT_WIDTH-1:0]  mispred_count
);

    localparam int IDX_W = $clog2(BHT_DEPTH);

    logic [1:0]            bht [BHT_DEPTH];

    logic                  s1_valid;
    logic [2:0]            s1_cond;
    logic [18:0]           s1_off;
    logic [DATA_WIDTH-1:0] s1_data;
    logic [PC_WIDTH-1:0]   s1_pc;
    logic                  s1_pred;

    logic                  s2_valid;
    logic                  s2_taken;
    logic                  s2_pred;
    logic                  s2_mispred;
    logic [PC_WIDTH-1:0]   s2_target;
    logic [IDX_W-1:0]      s2_idx;

    logic                  complete;
    logic                  s2_load;
    logic                  s1_move;
    logic                  accept;
    logic [IDX_W-1:0]      req_idx;
    logic [2:0]            cond_in;
    logic [1:0]            bht_upd;
    logic                  pred_rd;
    logic                  s1_taken;
    logic [PC_WIDTH-1:0]   s1_target;
    logic                  unused_ir;

    assign complete  = s2_valid & resp_ready;
    assign s2_load   = !s2_valid | complete;
    assign s1_move   = s1_valid & s2_load;
    assign req_ready = !s1_valid | s1_move;
    assign accept    = req_valid & req_ready;
    assign req_idx   = pc[IDX_W-1:0];
    assign cond_in   = (EXT_MODES != 0) ? ir[21:19] : {1'b0, ir[20:19]};
    assign unused_ir = ^{ir[31:21]};

    always_comb begin
        bht_upd = bht[s2_idx];
        if (s2_taken) begin
            if (bht[s2_idx] != 2'b11) bht_upd = bht[s2_idx] + 2'b01;
        end else begin
            if (bht[s2_idx] != 2'b00) bht_upd = bht[s2_idx] - 2'b01;
        end
    end

    // A completion writing the same entry this cycle must be visible to the new request.
    assign pred_rd = (complete && (s2_idx == req_idx)) ? bht_upd[1] : bht[req_idx][1];

    always_comb begin
        s1_taken = 1'b0;
        case (s1_cond)
            3'b000:  s1_taken = (s1_data == '0);
            3'b001:  s1_taken = (s1_data != '0);
            3'b010:  s1_taken = !s1_data[DATA_WIDTH-1];
            3'b011:  s1_taken = s1_data[DATA_WIDTH-1];
            3'b100:  s1_taken = !s1_data[DATA_WIDTH-1] && (s1_data != '0);
            3'b101:  s1_taken = s1_data[DATA_WIDTH-1] || (s1_data == '0);
            3'b110:  s1_taken = 1'b1;
            default: s1_taken = 1'b0;
        endcase
    end

    assign s1_target = s1_pc + PC_WIDTH'($signed(s1_off));

    always_ff @(posedge clock) begin
        if (reset) begin
            s1_valid      <= 1'b0;
            s1_cond       <= '0;
            s1_off        <= '0;
            s1_data       <= '0;
            s1_pc         <= '0;
            s1_pred       <= 1'b0;
            s2_valid      <= 1'b0;
            s2_taken      <= 1'b0;
            s2_pred       <= 1'b0;
            s2_mispred    <= 1'b0;
            s2_target     <= '0;
            s2_idx        <= '0;
            con_out       <= 1'b0;
            taken_count   <= '0;
            mispred_count <= '0;
            for (int i = 0; i < BHT_DEPTH; i++) bht[i] <= 2'b01;
        end else begin
            if (accept) begin
                s1_valid <= 1'b1;
                s1_cond  <= cond_in;
                s1_off   <= ir[18:0];
                s1_data  <= data;
                s1_pc    <= pc;
                s1_pred  <= pred_rd;
            end else if (s1_move) begin
                s1_valid <= 1'b0;
            end

            if (s2_load) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    s2_taken   <= s1_taken;
                    s2_pred    <= s1_pred;
                    s2_mispred <= s1_taken ^ s1_pred;
                    s2_target  <= s1_target;
                    s2_idx     <= s1_pc[IDX_W-1:0];
                end
            end

            if (complete) begin
                bht[s2_idx] <= bht_upd;
                con_out     <= s2_taken;
                if (s2_taken && (taken_count != '1))
                    taken_count <= taken_count + 1'b1;
                if (s2_mispred && (mispred_count != '1))
                    mispred_count <= mispred_count + 1'b1;
            end
        end
    end

    assign resp_valid   = s2_valid;
    assign resp_taken   = s2_taken;
    assign resp_pred    = s2_pred;
    assign resp_mispred = s2_mispred;
    assign resp_target  = s2_target;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Bench for branch_resolve_unit: transaction-level scoreboard checked every cycle plus directed literal cases.
module tb_branch_resolve_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] ir;
    logic [31:0] data;
    logic [31:0] pc;
    logic        resp_valid;
    logic        resp_ready;
    logic        resp_taken;
    logic        resp_pred;
    logic        resp_mispred;
    logic [31:0] resp_target;
    logic        con_out;
    logic [15:0] taken_count;
    logic [15:0] mispred_count;

    logic        unused_d2_req_ready;
    logic        d2_resp_valid;
    logic        d2_resp_taken;
    logic        unused_d2_pred;
    logic        unused_d2_mispred;
    logic [31:0] unused_d2_target;
    logic        unused_d2_con;
    logic [15:0] unused_d2_tcnt;
    logic [15:0] unused_d2_mcnt;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    branch_resolve_unit dut (
        .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .ir(ir), .data(data), .pc(pc), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_taken(resp_taken), .resp_pred(resp_pred), .resp_mispred(resp_mispred),
        .resp_target(resp_target), .con_out(con_out), .taken_count(taken_count),
        .mispred_count(mispred_count)
    );

    branch_resolve_unit #(.EXT_MODES(0)) dut2 (
        .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(unused_d2_req_ready),
        .ir(ir), .data(data), .pc(pc), .resp_valid(d2_resp_valid), .resp_ready(resp_ready),
        .resp_taken(d2_resp_taken), .resp_pred(unused_d2_pred), .resp_mispred(unused_d2_mispred),
        .resp_target(unused_d2_target), .con_out(unused_d2_con), .taken_count(unused_d2_tcnt),
        .mispred_count(unused_d2_mcnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        logic        taken;
        logic        pred;
        logic [31:0] target;
        int          idx;
        int          acc;
    } exp_t;

    exp_t q[$];
    int   m_cnt[16];
    int   m_taken_cnt = 0;
    int   m_mis_cnt   = 0;
    logic m_con       = 1'b0;
    int   cyc         = 0;

    initial foreach (m_cnt[i]) m_cnt[i] = 1;

    function automatic logic m_cond(input logic [2:0] c, input logic [31:0] d);
        logic z, n;
        z = (d == 0);
        n = d[31];
        case (c)
            3'd0: return z;
            3'd1: return !z;
            3'd2: return !n;
            3'd3: return n;
            3'd4: return !n && !z;
            3'd5: return n || z;
            3'd6: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    always @(negedge clock) begin
        logic rv, comp, rr;
        exp_t e;
        int   off;
        rv   = (q.size() > 0) && (cyc >= q[0].acc + 2);
        comp = rv && resp_ready;
        rr   = !(q.size() == 2 && !comp);
        chk("m_req_ready", req_ready, rr);
        chk("m_resp_valid", resp_valid, rv);
        chk("m_con_out", con_out, m_con);
        chk("m_taken_count", taken_count, m_taken_cnt);
        chk("m_mispred_count", mispred_count, m_mis_cnt);
        if (rv) begin
            chk("m_resp_taken", resp_taken, q[0].taken);
            chk("m_resp_pred", resp_pred, q[0].pred);
            chk("m_resp_mispred", resp_mispred, q[0].taken != q[0].pred);
            chk("m_resp_target", resp_target, q[0].target);
        end
        if (reset) begin
            q.delete();
            foreach (m_cnt[i]) m_cnt[i] = 1;
            m_taken_cnt = 0;
            m_mis_cnt   = 0;
            m_con       = 1'b0;
        end else begin
            if (comp) begin
                e = q.pop_front();
                if (e.taken) m_cnt[e.idx] = (m_cnt[e.idx] < 3) ? m_cnt[e.idx] + 1 : 3;
                else         m_cnt[e.idx] = (m_cnt[e.idx] > 0) ? m_cnt[e.idx] - 1 : 0;
                m_con = e.taken;
                if (e.taken) m_taken_cnt++;
                if (e.taken != e.pred) m_mis_cnt++;
            end
            if (req_valid && rr) begin
                off      = ir[18] ? int'(ir[18:0]) - 524288 : int'(ir[18:0]);
                e.taken  = m_cond(ir[21:19], data);
                e.idx    = int'(pc % 16);
                e.pred   = (m_cnt[e.idx] >= 2);
                e.target = pc + off;
                e.acc    = cyc;
                q.push_back(e);
            end
        end
        cyc++;
    end

    // ---------------- directed stimulus ----------------
    function automatic logic [31:0] mk_ir(input logic [2:0] c, input logic [18:0] off);
        return {10'b0, c, off};
    endfunction

    task automatic send(input logic [31:0] i, input logic [31:0] d, input logic [31:0] p);
        logic got;
        got = 1'b0;
        req_valid = 1'b1; ir = i; data = d; pc = p;
        for (int k = 0; k < 30; k++) begin
            @(negedge clock);
            if (req_ready) begin got = 1'b1; break; end
        end
        if (!got) begin errors++; $display("FAIL send_timeout: got no accept, expected accept within 30 cycles"); end
        @(posedge clock); #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_resp(output logic t, output logic p, output logic m,
                             output logic [31:0] tg, output logic t2);
        logic got;
        got = 1'b0;
        t = 1'bx; p = 1'bx; m = 1'bx; tg = 'x; t2 = 1'bx;
        resp_ready = 1'b1;
        for (int k = 0; k < 30; k++) begin
            @(negedge clock);
            if (resp_valid) begin
                got = 1'b1;
                t = resp_taken; p = resp_pred; m = resp_mispred; tg = resp_target;
                t2 = d2_resp_valid ? d2_resp_taken : 1'bx;
                break;
            end
        end
        if (!got) begin errors++; $display("FAIL resp_timeout: got no response, expected one within 30 cycles"); end
        @(posedge clock); #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
    endtask

    logic        t, p, m, t2;
    logic [31:0] tg;
    logic [7:0]  mask [3];
    logic [31:0] dval [3];
    int          acc;
    logic [2:0]  c3;

    initial begin
        reset = 1'b1; req_valid = 1'b0; resp_ready = 1'b1; ir = 0; data = 0; pc = 0;
        mask[0] = 8'h65; dval[0] = 32'h0;
        mask[1] = 8'h56; dval[1] = 32'h5;
        mask[2] = 8'h6A; dval[2] = 32'h8000_0000;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;

        @(negedge clock);
        chk("rst_req_ready", req_ready, 1);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_con_out", con_out, 0);
        chk("rst_taken_count", taken_count, 0);
        @(posedge clock); #1;

        // zr with data=0 into a fresh predictor entry
        send(mk_ir(3'd0, 19'h00004), 32'h0, 32'h10);
        wait_resp(t, p, m, tg, t2);
        chk("zr_taken", t, 1);
        chk("zr_target", tg, 32'h14);
        chk("zr_pred", p, 0);
        chk("zr_mispred", m, 1);
        @(negedge clock);
        chk("zr_con_out", con_out, 1);
        chk("zr_mispred_count", mispred_count, 1);
        @(posedge clock); #1;

        for (int di = 0; di < 3; di++) begin
            for (int c = 0; c < 8; c++) begin
                c3 = 3'(c);
                send(mk_ir(c3, 19'h0), dval[di], 32'h100 + 32'(c));
                wait_resp(t, p, m, tg, t2);
                chk($sformatf("cond%0d_d%0d", c, di), t, mask[di][c]);
                chk($sformatf("ext0_cond%0d_d%0d", c, di), t2, mask[di][c3[1:0]]);
            end
        end

        send(mk_ir(3'd6, 19'h7FFFE), 32'h0, 32'h2);
        wait_resp(t, p, m, tg, t2);
        chk("tgt_wrap_zero", tg, 32'h0);
        send(mk_ir(3'd6, 19'h7FFFF), 32'h0, 32'h0);
        wait_resp(t, p, m, tg, t2);
        chk("tgt_wrap_ones", tg, 32'hFFFF_FFFF);
        send(mk_ir(3'd6, 19'h40000), 32'h0, 32'h1000);
        wait_resp(t, p, m, tg, t2);
        chk("tgt_min_off", tg, 32'hFFFC_1000);

        // predictor walk at index 3: 01 -> 10 -> 11 -> 11, then a not-taken drops it to 10
        do_reset();
        send(mk_ir(3'd6, 19'h0), 32'h0, 32'h13); wait_resp(t, p, m, tg, t2); chk("bht_pred0", p, 0);
        send(mk_ir(3'd6, 19'h0), 32'h0, 32'h13); wait_resp(t, p, m, tg, t2); chk("bht_pred1", p, 1);
        send(mk_ir(3'd6, 19'h0), 32'h0, 32'h13); wait_resp(t, p, m, tg, t2); chk("bht_pred2", p, 1);
        send(mk_ir(3'd7, 19'h0), 32'h0, 32'h13); wait_resp(t, p, m, tg, t2);
        chk("bht_nt_pred", p, 1);
        chk("bht_nt_mispred", m, 1);
        send(mk_ir(3'd6, 19'h0), 32'h0, 32'h13); wait_resp(t, p, m, tg, t2);
        chk("bht_after_nt_pred", p, 1);
        chk("bht_after_nt_mispred", m, 0);

        // back-to-back requests against a stalled consumer
        resp_ready = 1'b0; req_valid = 1'b1; ir = mk_ir(3'd6, 19'h0); data = 0; pc = 32'h20;
        acc = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            if (req_ready) acc++;
            if (k >= 2) begin
                chk("stall_valid", resp_valid, 1);
                chk("stall_target", resp_target, 32'h20);
            end
            @(posedge clock); #1;
            pc = 32'h20 + 32'(acc);
        end
        chk("stall_accepts", acc, 2);
        req_valid = 1'b0; resp_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            if (k < 2) begin
                chk("drain_valid", resp_valid, 1);
                chk("drain_target", resp_target, 32'h20 + 32'(k));
            end else begin
                chk("drain_empty", resp_valid, 0);
            end
            @(posedge clock); #1;
        end

        // reset with both stages occupied and the consumer ready
        resp_ready = 1'b0;
        send(mk_ir(3'd6, 19'h0), 32'h0, 32'h25);
        send(mk_ir(3'd6, 19'h0), 32'h0, 32'h26);
        resp_ready = 1'b1;
        do_reset();
        @(negedge clock);
        chk("rst2_resp_valid", resp_valid, 0);
        chk("rst2_taken_count", taken_count, 0);
        chk("rst2_mispred_count", mispred_count, 0);
        chk("rst2_con_out", con_out, 0);
        chk("rst2_req_ready", req_ready, 1);
        @(posedge clock); #1;
        send(mk_ir(3'd6, 19'h0), 32'h0, 32'h25);
        wait_resp(t, p, m, tg, t2);
        chk("rst2_pred", p, 0);

        repeat (3) @(posedge clock);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
